lcd_timing_ctrl: RTL and testbench

Timing controller that sequences the 800x480 LCD bar-pattern datapath. It generates the panel clock (NCLK = CLK/2), the panel reset GREST, and HD, VD and DEN. It also publishes pixel coordinates so a pixel source can produce R/G/B in step with the panel. Start/stop is controlled by ENABLE, with clean frame-boundary shutdown.

---
 rtl/lcd_timing_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_ctrl.sv
// Panel timing sequencer: NCLK = CLK/2, GREST, HD/VD/DEN and active pixel COL/ROW, frame-boundary stop.
// Define LCD_FRAME_CNT_EN to add a 16-bit FRAME_CNT output counting FRAME_START pulses.
module lcd_timing_ctrl #(
   parameter int H_ACTIVE    = 800,
   parameter int H_FRONT     = 40,
   parameter int H_SYNC      = 1,
   parameter int H_BACK      = 215,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 1,
   parameter int V_BACK      = 34,
   parameter int GREST_TICKS = 16
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        ENABLE,
   output logic        NCLK,
   output logic        GREST,
   output logic        HD,
   output logic        VD,
   output logic        DEN,
   output logic [9:0]  COL,
   output logic [8:0]  ROW,
   output logic        FRAME_START,
   output logic        BUSY
`ifdef LCD_FRAME_CNT_EN
   ,
   output logic [15:0] FRAME_CNT
`endif
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_START = H_SYNC + H_BACK;
   localparam int V_START = V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int GW      = $clog2(GREST_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RESET_WAIT, S_RUN, S_DRAIN} state_t;

   state_t        state_reg, state_next;
   logic          ph_reg;
   logic [HW-1:0] hcnt_reg, hcnt_next, hcnt_adv;
   logic [VW-1:0] vcnt_reg, vcnt_next, vcnt_adv;
   logic [GW-1:0] gcnt_reg, gcnt_next;
   logic          tick, h_last, v_last;
   logic          active_next, h_in, v_in;
   logic          hd_next, vd_next, den_next, fs_next;
   logic [9:0]    col_next;
   logic [8:0]    row_next;

   // A pixel tick is the CLK edge on which NCLK falls.
   assign tick = ph_reg;
   assign NCLK = ph_reg;
   assign BUSY = (state_reg != S_IDLE);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         ph_reg    <= 1'b0;
         state_reg <= S_IDLE;
         hcnt_reg  <= '0;
         vcnt_reg  <= '0;
         gcnt_reg  <= '0;
      end else begin
         ph_reg <= ~ph_reg;
         if (tick) begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            vcnt_reg  <= vcnt_next;
            gcnt_reg  <= gcnt_next;
         end
      end
   end

   always_comb begin
      h_last     = (hcnt_reg == HW'(H_TOTAL - 1));
      v_last     = (vcnt_reg == VW'(V_TOTAL - 1));
      hcnt_adv   = h_last ? '0 : hcnt_reg + HW'(1);
      vcnt_adv   = vcnt_reg;
      if (h_last) begin
         vcnt_adv = v_last ? '0 : vcnt_reg + VW'(1);
      end
      state_next = state_reg;
      hcnt_next  = hcnt_reg;
      vcnt_next  = vcnt_reg;
      gcnt_next  = gcnt_reg;
      case (state_reg)
         S_IDLE: begin
            hcnt_next = '0;
            vcnt_next = '0;
            gcnt_next = '0;
            if (ENABLE) state_next = S_RESET_WAIT;
         end
         S_RESET_WAIT: begin
            if (!ENABLE) begin
               state_next = S_IDLE;
               gcnt_next  = '0;
            end else if (gcnt_reg == GW'(GREST_TICKS - 1)) begin
               state_next = S_RUN;
               gcnt_next  = '0;
               hcnt_next  = '0;
               vcnt_next  = '0;
            end else begin
               gcnt_next = gcnt_reg + GW'(1);
            end
         end
         S_RUN: begin
            hcnt_next = hcnt_adv;
            vcnt_next = vcnt_adv;
            // Stopping on the very last tick of a frame skips DRAIN entirely.
            if (!ENABLE) state_next = (h_last && v_last) ? S_IDLE : S_DRAIN;
         end
         default: begin
            hcnt_next = hcnt_adv;
            vcnt_next = vcnt_adv;
            if (ENABLE)                state_next = S_RUN;
            else if (h_last && v_last) state_next = S_IDLE;
         end
      endcase
   end

   // Output values are derived from the post-tick counters so they land on the same tick.
   always_comb begin
      active_next = (state_next == S_RUN) || (state_next == S_DRAIN);
      h_in        = (hcnt_next >= HW'(H_START)) && (hcnt_next < HW'(H_START + H_ACTIVE));
      v_in        = (vcnt_next >= VW'(V_START)) && (vcnt_next < VW'(V_START + V_ACTIVE));
      hd_next     = !(active_next && (hcnt_next < HW'(H_SYNC)));
      vd_next     = !(active_next && (vcnt_next < VW'(V_SYNC)));
      den_next    = active_next && h_in && v_in;
      col_next    = '0;
      row_next    = '0;
      if (den_next) begin
         col_next = 10'(hcnt_next - HW'(H_START));
         row_next = 9'(vcnt_next - VW'(V_START));
      end
      fs_next = (state_next == S_RUN) && (hcnt_next == '0) && (vcnt_next == '0);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         GREST       <= 1'b0;
         HD          <= 1'b1;
         VD          <= 1'b1;
         DEN         <= 1'b0;
         COL         <= '0;
         ROW         <= '0;
         FRAME_START <= 1'b0;
      end else begin
         FRAME_START <= tick && fs_next;
         if (tick) begin
            GREST <= active_next;
            HD    <= hd_next;
            VD    <= vd_next;
            DEN   <= den_next;
            COL   <= col_next;
            ROW   <= row_next;
         end
      end
   end

`ifdef LCD_FRAME_CNT_EN
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         FRAME_CNT <= '0;
      end else if (tick) begin
         if ((state_reg != S_IDLE) && (state_next == S_IDLE)) FRAME_CNT <= '0;
         else if (fs_next)                                    FRAME_CNT <= FRAME_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Scoreboarded bench for lcd_timing_ctrl using a reduced panel geometry so whole frames fit the run.
module tb_lcd_timing_ctrl;

   localparam int H_ACTIVE = 8, H_FRONT = 3, H_SYNC = 2, H_BACK = 3;
   localparam int V_ACTIVE = 5, V_FRONT = 2, V_SYNC = 2, V_BACK = 2;
   localparam int GREST_TICKS = 4;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_START = H_SYNC + H_BACK;
   localparam int V_START = V_SYNC + V_BACK;
   localparam int FRAME   = H_TOTAL * V_TOTAL;

   logic       CLK = 1'b0;
   logic       RST_n, ENABLE;
   logic       NCLK, GREST, HD, VD, DEN, FRAME_START, BUSY;
   logic [9:0] COL;
   logic [8:0] ROW;
`ifdef LCD_FRAME_CNT_EN
   logic [15:0] FRAME_CNT;
   localparam int VECW = 42;
`else
   localparam int VECW = 26;
`endif
   typedef logic [VECW-1:0] vec_t;

   lcd_timing_ctrl #(
      .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
      .GREST_TICKS(GREST_TICKS)
   ) dut (
      .CLK(CLK), .RST_n(RST_n), .ENABLE(ENABLE), .NCLK(NCLK), .GREST(GREST),
      .HD(HD), .VD(VD), .DEN(DEN), .COL(COL), .ROW(ROW),
      .FRAME_START(FRAME_START), .BUSY(BUSY)
`ifdef LCD_FRAME_CNT_EN
      , .FRAME_CNT(FRAME_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_go = 1'b0;
   event async_chk;

   // Reference model: mode 0 idle, 1 panel reset hold, 2 scanning; pos = tick index within the frame.
   int          m_mode, m_wait, m_pos;
   bit          m_ph, m_fs;
   logic [15:0] m_fcnt;

   task automatic model_reset();
      m_mode = 0; m_wait = 0; m_pos = 0; m_ph = 1'b0; m_fs = 1'b0; m_fcnt = '0;
   endtask

   task automatic model_edge(input bit en);
      m_fs = 1'b0;
      if (m_ph) begin
         case (m_mode)
            0: if (en) begin m_mode = 1; m_wait = 0; end
            1: begin
               if (!en) begin
                  m_mode = 0; m_fcnt = '0;
               end else begin
                  m_wait++;
                  if (m_wait == GREST_TICKS) begin
                     m_mode = 2; m_pos = 0; m_fs = 1'b1; m_fcnt++;
                  end
               end
            end
            default: begin
               if (m_pos == FRAME - 1 && !en) begin
                  m_mode = 0; m_pos = 0; m_fcnt = '0;
               end else begin
                  m_pos = (m_pos + 1) % FRAME;
                  if (m_pos == 0) begin m_fs = 1'b1; m_fcnt++; end
               end
            end
         endcase
      end
      m_ph = !m_ph;
   endtask

   function automatic vec_t model_vec();
      int h, v;
      bit act, den;
      logic [9:0] col;
      logic [8:0] row;
      vec_t r;
      act = (m_mode == 2);
      h   = act ? m_pos % H_TOTAL : 0;
      v   = act ? m_pos / H_TOTAL : 0;
      den = act && h >= H_START && h < H_START + H_ACTIVE && v >= V_START && v < V_START + V_ACTIVE;
      col = den ? 10'(h - H_START) : 10'd0;
      row = den ? 9'(v - V_START) : 9'd0;
`ifdef LCD_FRAME_CNT_EN
      r = {m_ph, act, !(act && h < H_SYNC), !(act && v < V_SYNC), den, col, row, m_fs, m_mode != 0, m_fcnt};
`else
      r = {m_ph, act, !(act && h < H_SYNC), !(act && v < V_SYNC), den, col, row, m_fs, m_mode != 0};
`endif
      return r;
   endfunction

   function automatic vec_t dut_vec();
      vec_t r;
`ifdef LCD_FRAME_CNT_EN
      r = {NCLK, GREST, HD, VD, DEN, COL, ROW, FRAME_START, BUSY, FRAME_CNT};
`else
      r = {NCLK, GREST, HD, VD, DEN, COL, ROW, FRAME_START, BUSY};
`endif
      return r;
   endfunction

   function automatic bit model_at_col(input int c);
      int h, v;
      h = m_pos % H_TOTAL;
      v = m_pos / H_TOTAL;
      return (m_mode == 2) && (h - H_START == c) && v >= V_START && v < V_START + V_ACTIVE;
   endfunction

   // One CLK of stimulus: inputs change on the falling edge, expectation for the next rising edge is queued.
   task automatic drive_cycle(input bit en, input bit rst_v);
      @(negedge CLK);
      RST_n  = rst_v;
      ENABLE = en;
      if (RST_n) model_edge(en);
      exp_q.push_back(model_vec());
      mon_go = 1'b1;
   endtask

   task automatic async_reset_mid_cycle();
      @(negedge CLK);
      #2;
      RST_n = 1'b0;
      model_reset();
      exp_q.push_back(model_vec());
      -> async_chk;
      exp_q.push_back(model_vec());
   endtask

   task automatic bound_fail(input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired, got no match, required match within budget", what);
   endtask

   task automatic drain_to_idle(input string what);
      int n;
      n = 0;
      while (m_mode != 0 && n < 3 * FRAME) begin drive_cycle(1'b0, 1'b1); n++; end
      if (m_mode != 0) bound_fail(what);
      repeat (40) drive_cycle(1'b0, 1'b1);
   endtask

   // Monitor: each rising edge (or asynchronous reset probe) pops one expectation and compares.
   initial begin
      vec_t e, a;
      wait (mon_go);
      forever begin
         @(posedge CLK or async_chk);
         #1;
         a = dut_vec();
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard @%0t: got empty queue, required an expectation", $time);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               n_bad++;
               $display("FAIL outputs @%0t: got %h required %h", $time, a, e);
            end
         end
      end
   end

   initial begin
      int n, len;
      bit en;
      RST_n = 1'b0;
      ENABLE = 1'b0;
      model_reset();
      repeat (3) drive_cycle(1'b0, 1'b0);
      $display("txn 0: reset release, ENABLE=1 for two frames");
      repeat (4 * FRAME + 2 * GREST_TICKS + 8) drive_cycle(1'b1, 1'b1);

      $display("txn 1: ENABLE dropped 60 CLK mid-frame then restored");
      repeat (60) drive_cycle(1'b0, 1'b1);
      repeat (2 * FRAME) drive_cycle(1'b1, 1'b1);

      $display("txn 2: ENABLE dropped, drain to idle");
      drain_to_idle("drain_idle");

      $display("txn 3: ENABLE falls exactly on last tick of a frame");
      n = 0;
      while (!(m_mode == 2 && m_ph && m_pos == FRAME - 1) && n < 6 * FRAME) begin
         drive_cycle(1'b1, 1'b1);
         n++;
      end
      if (!(m_mode == 2 && m_ph && m_pos == FRAME - 1)) bound_fail("last_tick_stop");
      repeat (40) drive_cycle(1'b0, 1'b1);

      for (int s = 0; s < 16; s++) begin
         en  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * FRAME);
         $display("txn %0d: random ENABLE=%0b for %0d CLK", s + 4, en, len);
         repeat (len) drive_cycle(en, 1'b1);
      end

      $display("txn 20: asynchronous reset at COL=%0d, then restart with ENABLE=1", H_ACTIVE / 2);
      n = 0;
      while (!model_at_col(H_ACTIVE / 2) && n < 8 * FRAME) begin
         drive_cycle(1'b1, 1'b1);
         n++;
      end
      if (!model_at_col(H_ACTIVE / 2)) bound_fail("midline_reset_reach");
      async_reset_mid_cycle();
      repeat (2) drive_cycle(1'b1, 1'b0);
      repeat (4 * FRAME + 2 * GREST_TICKS + 8) drive_cycle(1'b1, 1'b1);

      $display("txn 21: final drain to idle");
      drain_to_idle("final_drain");

      @(posedge CLK);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
